disp_scan_ctrl: RTL and testbench
=================================

// Module: disp_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for the 4-digit 7-segment display. Drives the
//  2-bit digit select consumed by the 2:4 one-hot select decoder, plus active-low
//  anode and cathode lines. Double-buffers the 16-bit hex value so the image only
//  changes on frame boundaries. Inserts an all-off gap between digits to stop ghosting.
// PARAMETERS
//  DIV  50000  CLK cycles each digit is lit (>=2)
//  GAP  16     CLK cycles all anodes off between digits (0 = no gap)
// PORTS
//  CLK      in   1   system clock, rising edge
//  RST      in   1   asynchronous, active-high reset
//  EN       in   1   scan enable; 0 = display dark
//  LOAD     in   1   1-cycle strobe: capture DATA_IN/DP_IN into shadow
//  DATA_IN  in   16  4 hex nibbles, [3:0]=digit 0 (rightmost)
//  DP_IN    in   4   decimal points, active-high, bit i = digit i
//  BLANK_LZ in   1   1 = blank leading zero digits (digit 0 never blanked)
//  SEL      out  2   current digit index, to the 2:4 decoder
//  ANODES   out  4   active-low anode enables (one-cold while lit)
//  SEGS     out  8   active-low {dp,g,f,e,d,c,b,a}
//  FRAME    out  1   1-cycle pulse when the active buffer is updated
// BEHAVIOUR
//  - Reset: state OFF, SEL=0, ANODES=4'hF, SEGS=8'hFF, FRAME=0, cnt=0,
//    shadow=active=0, DP shadow/active=0, pending=0.
//  - FSM OFF/ON/GAP. OFF: EN=1 -> ON, SEL=0, cnt=0. ON: cnt 0..DIV-1; at DIV-1
//    -> GAP (GAP>0) or ON with SEL+1 (GAP=0); cnt->0. GAP: cnt 0..GAP-1; at GAP-1
//    -> ON, SEL+1 (3 wraps to 0), cnt->0.
//  - EN=0 in any state: next edge -> OFF, SEL=0, cnt=0, outputs dark. Mid-digit
//    abort is legal; re-enable always restarts at digit 0.
//  - Outputs registered; valid the cycle after state/SEL update. ON: ANODES=
//    ~(4'b0001<<SEL), SEGS={~DP[SEL], hex(nib[SEL])}. OFF/GAP: ANODES=4'hF, SEGS=8'hFF.
//  - Hex table (SEGS incl. dp off): 0 C0,1 F9,2 A4,3 B0,4 99,5 92,6 82,7 F8,
//    8 80,9 90,A 88,b 83,C C6,d A1,E 86,F 8E. dp on clears bit 7.
//  - Leading-zero blank: BLANK_LZ=1, digit i>0 with nibbles i..3 all zero and
//    DP_IN bits i..3 all zero -> that digit dark (ANODES=4'hF, SEGS=8'hFF) for its
//    slot; timing unchanged.
//  - LOAD: shadow<=DATA_IN/DP_IN, pending<=1. Repeated LOADs: last wins.
//  - Frame boundary = SEL wrapping 3->0 (or OFF->ON entry). If pending: active<=
//    shadow, pending<=0, FRAME=1 same cycle. If no pending: FRAME stays 0.
//  - LOAD on boundary cycle: active<=DATA_IN/DP_IN directly, pending=0, FRAME=1.
//  - Frame period = 4*(DIV+GAP) cycles. BLANK_LZ is sampled live (not buffered).
//  - Counter width = clog2(max(DIV,GAP,2)); no overflow: cnt never exceeds DIV-1.
//  - RST mid-operation: immediate return to reset values; shadow contents lost.
// TESTING (DIV=4, GAP=2)
//  1 RST, EN=1, LOAD 16'h1234 -> after first boundary: FRAME pulse; SEL steps
//    0,1,2,3 every 6 cycles; digit0 SEGS=8'h99 ANODES=4'hE for 4 cycles then
//    4'hF for 2; digit3 SEGS=8'hF9 ANODES=4'h7.
//  2 LOAD 16'hABCD mid-frame at SEL=1 -> digits 1..3 still show 1234 values;
//    new value appears at digit 0 after wrap, FRAME=1 exactly once.
//  3 BLANK_LZ=1, LOAD 16'h0007 -> digit0 SEGS=8'hF8; digits 1..3 ANODES=4'hF
//    whole slot; DP_IN=4'b0100 re-lights digits 1,2 (digit2 SEGS=8'h40).
//  4 EN dropped during digit 2 lit -> next edge ANODES=4'hF, SEL=0; EN=1 -> ON
//    at SEL=0 with cnt=0, full DIV-cycle lit time.
//  5 LOAD asserted on the exact wrap cycle -> active=DATA_IN that cycle, FRAME=1,
//    pending=0 (no second FRAME at next wrap).
//  6 RST asserted asynchronously mid-GAP -> outputs reach reset values without a
//    clock edge; GAP=0 build: no dark cycles between digits, period 16 cycles.

Source files
------------

// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - 4-digit 7-segment scan controller with frame-synchronous double buffer
//
// Scans four digits in turn. Each digit is lit for DIV clocks, followed by GAP
// clocks with every anode off so the previous digit does not ghost into the
// next. A new hex value captured by LOAD sits in a shadow buffer and is only
// copied into the displayed (active) buffer at the start of a frame, so a frame
// never shows a mix of old and new digits.
//
// Ports:
//   CLK      in   1   system clock, rising edge
//   RST      in   1   asynchronous active-high reset
//   EN       in   1   scan enable, 0 = display dark
//   LOAD     in   1   one-cycle strobe capturing DATA_IN/DP_IN
//   DATA_IN  in  16   four hex nibbles, [3:0] = digit 0 (rightmost)
//   DP_IN    in   4   decimal points, active high, bit i = digit i
//   BLANK_LZ in   1   blank leading zero digits (digit 0 is never blanked)
//   SEL      out  2   current digit index for the 2:4 decoder
//   ANODES   out  4   active-low anode enables
//   SEGS     out  8   active-low {dp,g,f,e,d,c,b,a}
//   FRAME    out  1   one-cycle pulse when the active buffer is updated

module disp_scan_ctrl #(
  parameter int DIV = 50000,
  parameter int GAP = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        LOAD,
  input  logic [15:0] DATA_IN,
  input  logic [3:0]  DP_IN,
  input  logic        BLANK_LZ,
  output logic [1:0]  SEL,
  output logic [3:0]  ANODES,
  output logic [7:0]  SEGS,
  output logic        FRAME
);

  localparam int MAXV = (DIV > GAP) ? ((DIV > 2) ? DIV : 2) : ((GAP > 2) ? GAP : 2);
  localparam int CW   = $clog2(MAXV);

  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP > 0) ? GAP - 1 : 0);

  localparam logic [1:0] S_OFF = 2'd0;
  localparam logic [1:0] S_ON  = 2'd1;
  localparam logic [1:0] S_GAP = 2'd2;

  logic [1:0]    st, st_n;
  logic [1:0]    sel_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          boundary;

  logic [15:0]   shadow, active;
  logic [3:0]    shadow_dp, active_dp;
  logic          pending;

  logic [3:0]    nib;
  logic          lz_dark;

  // Segment pattern {g,f,e,d,c,b,a}, active low.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Scan sequencing. boundary marks the edge that starts a new frame: entry
  // from OFF, or SEL wrapping from digit 3 back to digit 0.
  always_comb begin
    st_n     = st;
    sel_n    = SEL;
    cnt_n    = cnt;
    boundary = 1'b0;
    if (!EN) begin
      st_n  = S_OFF;
      sel_n = 2'd0;
      cnt_n = '0;
    end else begin
      case (st)
        S_OFF: begin
          st_n     = S_ON;
          sel_n    = 2'd0;
          cnt_n    = '0;
          boundary = 1'b1;
        end
        S_ON: begin
          if (cnt == DIV_LAST) begin
            cnt_n = '0;
            if (GAP > 0) begin
              st_n = S_GAP;
            end else begin
              sel_n    = SEL + 2'd1;
              boundary = (SEL == 2'd3);
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt_n    = '0;
            st_n     = S_ON;
            sel_n    = SEL + 2'd1;
            boundary = (SEL == 2'd3);
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          st_n  = S_OFF;
          sel_n = 2'd0;
          cnt_n = '0;
        end
      endcase
    end
  end

  // Nibble of the digit being scanned, and whether it is a blanked leading
  // zero (it and every digit to its left are zero with no decimal point).
  always_comb begin
    nib     = active[3:0];
    lz_dark = 1'b0;
    case (SEL)
      2'd0: nib = active[3:0];
      2'd1: begin
        nib     = active[7:4];
        lz_dark = (active[15:4] == 12'h0) && (active_dp[3:1] == 3'b0);
      end
      2'd2: begin
        nib     = active[11:8];
        lz_dark = (active[15:8] == 8'h0) && (active_dp[3:2] == 2'b0);
      end
      default: begin
        nib     = active[15:12];
        lz_dark = (active[15:12] == 4'h0) && !active_dp[3];
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st  <= S_OFF;
      SEL <= 2'd0;
      cnt <= '0;
    end else begin
      st  <= st_n;
      SEL <= sel_n;
      cnt <= cnt_n;
    end
  end

  // Outputs follow the scan state one cycle later; dropping EN darkens them
  // on the very next edge rather than after the lag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ANODES <= 4'hF;
      SEGS   <= 8'hFF;
    end else if (!EN || st != S_ON || (BLANK_LZ && lz_dark)) begin
      ANODES <= 4'hF;
      SEGS   <= 8'hFF;
    end else begin
      ANODES <= ~(4'b0001 << SEL);
      SEGS   <= {~active_dp[SEL], hex7(nib)};
    end
  end

  // Double buffer. A LOAD coinciding with a frame boundary bypasses the
  // shadow and goes straight to the active buffer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shadow    <= 16'h0;
      shadow_dp <= 4'h0;
      active    <= 16'h0;
      active_dp <= 4'h0;
      pending   <= 1'b0;
      FRAME     <= 1'b0;
    end else if (boundary) begin
      FRAME   <= LOAD || pending;
      pending <= 1'b0;
      if (LOAD) begin
        active    <= DATA_IN;
        active_dp <= DP_IN;
      end else if (pending) begin
        active    <= shadow;
        active_dp <= shadow_dp;
      end
    end else begin
      FRAME <= 1'b0;
      if (LOAD) begin
        shadow    <= DATA_IN;
        shadow_dp <= DP_IN;
        pending   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb/tb_disp_scan_ctrl.sv - testbench for disp_scan_ctrl (GAP=2 and GAP=0 builds side by side)

module tb_disp_scan_ctrl;

  localparam int DIV = 4;
  localparam int GAPK [2] = '{2, 0};
  localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic        CLK = 1'b0;
  logic        RST, EN, LOAD, BLANK_LZ;
  logic [15:0] DATA_IN;
  logic [3:0]  DP_IN;

  logic [1:0]  sel_a, sel_b;
  logic [3:0]  an_a, an_b;
  logic [7:0]  seg_a, seg_b;
  logic        fr_a, fr_b;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: time since scan start gives digit and lit/gap by arithmetic.
  bit          running [2];
  int          t       [2];
  logic [15:0] act     [2];
  logic [15:0] shd     [2];
  logic [3:0]  adp     [2];
  logic [3:0]  sdp     [2];
  bit          pend    [2];
  logic [1:0]  e_sel   [2];
  logic [3:0]  e_an    [2];
  logic [7:0]  e_seg   [2];
  logic        e_fr    [2];

  always #5 CLK = ~CLK;

  disp_scan_ctrl #(.DIV(DIV), .GAP(2)) u_a (
    .CLK(CLK), .RST(RST), .EN(EN), .LOAD(LOAD), .DATA_IN(DATA_IN), .DP_IN(DP_IN),
    .BLANK_LZ(BLANK_LZ), .SEL(sel_a), .ANODES(an_a), .SEGS(seg_a), .FRAME(fr_a));

  disp_scan_ctrl #(.DIV(DIV), .GAP(0)) u_b (
    .CLK(CLK), .RST(RST), .EN(EN), .LOAD(LOAD), .DATA_IN(DATA_IN), .DP_IN(DP_IN),
    .BLANK_LZ(BLANK_LZ), .SEL(sel_b), .ANODES(an_b), .SEGS(seg_b), .FRAME(fr_b));

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      running[k] = 1'b0; t[k] = 0; pend[k] = 1'b0;
      act[k] = 16'h0; shd[k] = 16'h0; adp[k] = 4'h0; sdp[k] = 4'h0;
      e_sel[k] = 2'd0; e_an[k] = 4'hF; e_seg[k] = 8'hFF; e_fr[k] = 1'b0;
    end
  endfunction

  // Predicts the outputs after the coming clock edge from the current inputs.
  function automatic void model_edge(int k);
    int slot, per, d;
    logic [3:0] nib;
    bit bnd;
    slot = DIV + GAPK[k];
    per  = 4 * slot;
    e_an[k]  = 4'hF;
    e_seg[k] = 8'hFF;
    if (EN && running[k]) begin
      d   = (t[k] % per) / slot;
      nib = 4'(act[k] >> (4 * d));
      if ((t[k] % slot) < DIV &&
          !(BLANK_LZ && d > 0 && (act[k] >> (4 * d)) == 16'h0 && (adp[k] >> d) == 4'h0)) begin
        e_an[k]  = ~(4'b0001 << d);
        e_seg[k] = HEX[nib] & (adp[k][d] ? 8'h7F : 8'hFF);
      end
    end
    bnd = EN && (!running[k] || ((t[k] + 1) % per) == 0);
    if (!EN) begin
      running[k] = 1'b0; t[k] = 0;
    end else if (!running[k]) begin
      running[k] = 1'b1; t[k] = 0;
    end else begin
      t[k] = t[k] + 1;
    end
    e_sel[k] = running[k] ? 2'((t[k] % per) / slot) : 2'd0;
    if (bnd) begin
      e_fr[k] = LOAD || pend[k];
      if (LOAD) begin
        act[k] = DATA_IN; adp[k] = DP_IN;
      end else if (pend[k]) begin
        act[k] = shd[k]; adp[k] = sdp[k];
      end
      pend[k] = 1'b0;
    end else begin
      e_fr[k] = 1'b0;
      if (LOAD) begin
        shd[k] = DATA_IN; sdp[k] = DP_IN; pend[k] = 1'b1;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("sel_a", 8'(sel_a), 8'(e_sel[0]));
    chk("anodes_a", 8'(an_a), 8'(e_an[0]));
    chk("segs_a", seg_a, e_seg[0]);
    chk("frame_a", 8'(fr_a), 8'(e_fr[0]));
    chk("sel_b", 8'(sel_b), 8'(e_sel[1]));
    chk("anodes_b", 8'(an_b), 8'(e_an[1]));
    chk("segs_b", seg_b, e_seg[1]);
    chk("frame_b", 8'(fr_b), 8'(e_fr[1]));
  endtask

  task automatic step();
    model_edge(0);
    model_edge(1);
    @(posedge CLK);
    @(negedge CLK);
    check_all();
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] dp);
    DATA_IN = d; DP_IN = dp; LOAD = 1'b1;
    step();
    LOAD = 1'b0;
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; LOAD = 1'b0; DATA_IN = 16'h0; DP_IN = 4'h0; BLANK_LZ = 1'b0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    check_all();
    RST = 1'b0;

    // Value loaded while dark appears at the first frame after enable.
    load(16'h1234, 4'h0);
    EN = 1'b1;
    repeat (60) step();

    // Mid-frame load at digit 1 must wait for the wrap.
    for (int i = 0; i < 30 && e_sel[0] != 2'd1; i++) step();
    chk("reach_sel1", 8'(e_sel[0]), 8'd1);
    load(16'hABCD, 4'h0);
    repeat (50) step();

    // Leading-zero blanking, then a decimal point re-lighting digits 1 and 2.
    BLANK_LZ = 1'b1;
    load(16'h0007, 4'h0);
    repeat (50) step();
    load(16'h0007, 4'b0100);
    repeat (50) step();
    BLANK_LZ = 1'b0;

    // Enable dropped while digit 2 is lit.
    for (int i = 0; i < 30 && !(e_sel[0] == 2'd2 && (t[0] % 6) < 3); i++) step();
    chk("reach_sel2", 8'(e_sel[0]), 8'd2);
    EN = 1'b0;
    step();
    EN = 1'b1;
    repeat (30) step();

    // Load exactly on the wrap edge goes straight to the active buffer.
    for (int i = 0; i < 30 && ((t[0] + 1) % 24) != 0; i++) step();
    chk("reach_wrap", 8'(((t[0] + 1) % 24) == 0), 8'd1);
    load(16'h5E9F, 4'b1001);
    repeat (60) step();

    // Random traffic.
    repeat (400) begin
      EN       = ($urandom_range(0, 49) != 0);
      LOAD     = ($urandom_range(0, 9) == 0);
      DATA_IN  = 16'($urandom) >> (4 * $urandom_range(0, 3));
      DP_IN    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 19) == 0) BLANK_LZ = ~BLANK_LZ;
      step();
    end
    EN = 1'b1; LOAD = 1'b0; BLANK_LZ = 1'b0;
    repeat (2) step();

    // Asynchronous reset in the middle of a gap.
    for (int i = 0; i < 30 && !(running[0] && (t[0] % 6) >= 4); i++) step();
    chk("reach_gap", 8'(running[0] && (t[0] % 6) >= 4), 8'd1);
    #1 RST = 1'b1;
    #1;
    chk("async_sel_a", 8'(sel_a), 8'd0);
    chk("async_an_a", 8'(an_a), 8'hF);
    chk("async_seg_a", seg_a, 8'hFF);
    chk("async_fr_a", 8'(fr_a), 8'd0);
    chk("async_sel_b", 8'(sel_b), 8'd0);
    chk("async_an_b", 8'(an_b), 8'hF);
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    check_all();
    RST = 1'b0;
    load(16'h8421, 4'h2);
    repeat (40) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
